// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_slot_t;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with sequential-increment / redirect-load mux.
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4_c
);

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0.
  assign pc_plus4_c = pc + PC_INCR;

  // Redirect wins over the sequential increment.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc_plus4_c;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch FSM feeding a one-entry output slot.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [XLEN-1:0] IMemData,
  output logic [XLEN-1:0] PCAddResult,
  output logic [XLEN-1:0] Instruction,
  output logic            InstrValid
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic            pc_inc_c;
  logic            capture_c;
  logic            consume_c;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4_c;
  fetch_slot_t     slot;
  logic            slot_valid;

  program_counter #(
    .RESET_PC(RESET_PC)
  ) u_program_counter (
    .Clk       (Clk),
    .Reset     (Reset),
    .inc       (pc_inc_c),
    .load      (Redirect),
    .load_pc   (RedirectPC),
    .pc        (pc),
    .pc_plus4_c(pc_plus4_c)
  );

  assign IMemAddr    = pc;
  assign Instruction = slot.instr;
  assign PCAddResult = slot.pc_plus4;
  assign InstrValid  = slot_valid;
  assign consume_c   = slot_valid && !Stall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A redirect in WAIT still waits for the in-flight read before refetching.
  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    pc_inc_c   = 1'b0;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!Redirect && (!slot_valid || !Stall)) begin
          IMemReq    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (IMemAck) begin
          capture_c  = !Redirect;
          pc_inc_c   = !Redirect;
          state_next = IDLE;
        end else if (Redirect) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (IMemAck) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (Reset) begin
      IMemReq = 1'b0;
    end
  end

  // Output slot: capture beats flush, flush beats plain consumption.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot       <= '0;
      slot_valid <= 1'b0;
    end else if (capture_c) begin
      slot       <= '{instr: IMemData, pc_plus4: pc_plus4_c};
      slot_valid <= 1'b1;
    end else if (Redirect || consume_c) begin
      slot_valid <= 1'b0;
    end
  end

endmodule
